shim_cfg_sync_bank: RTL and testbench

//  Parametrised bank of config-field synchronisers from the AXI config domain into one destination

---
 rtl/shim_cfg_sync_bank_pkg.sv | 24 ++
 rtl/shim_cfg_field_sync.sv | 53 +++++
 rtl/shim_cfg_sync_bank.sv | 84 ++++++++
 tb/tb_shim_cfg_sync_bank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shim_cfg_sync_bank_pkg.sv
// Shared defaults and field map for the SPI-side config synchroniser bank.
package shim_cfg_sync_bank_pkg;

    localparam int unsigned DFLT_NUM_FIELDS   = 5;
    localparam int unsigned DFLT_FIELD_W      = 32;
    localparam int unsigned DFLT_DEPTH        = 3;
    localparam int unsigned DFLT_STABLE_COUNT = 2;

    // Field slot indices for the shim instance
    localparam int unsigned THRESH    = 0;
    localparam int unsigned WINDOW    = 1;
    localparam int unsigned INTEG_EN  = 2;
    localparam int unsigned SPI_EN    = 3;
    localparam int unsigned BLOCK_BUF = 4;

    localparam logic [DFLT_NUM_FIELDS-1:0] DFLT_GATE_MASK = 5'b00111;
    localparam logic [DFLT_NUM_FIELDS*DFLT_FIELD_W-1:0] DFLT_RESET_VAL = '0;

    // Counter width able to hold 0..n
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shim_cfg_field_sync.sv
// One config field: multi-flop synchroniser followed by a stability qualifier.
module shim_cfg_field_sync
    import shim_cfg_sync_bank_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     DEPTH        = 3,
    parameter int unsigned     STABLE_COUNT = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic             stable
);

    localparam int unsigned      CNT_W   = cnt_width(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

    logic [WIDTH-1:0] chain [DEPTH];
    logic [WIDTH-1:0] prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) chain[k] <= RESET_VAL;
        end else begin
            chain[0] <= din;
            for (int k = 1; k < int'(DEPTH); k++) chain[k] <= chain[k-1];
        end
    end

    assign sync = chain[DEPTH-1];

    // Saturating count of consecutive cycles the synchronised value held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= RESET_VAL;
            cnt  <= '0;
        end else begin
            prev <= sync;
            if (sync != prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Current-cycle equality keeps a value that just arrived from riding a stale saturated count
    assign stable = (cnt == CNT_MAX) && (sync == prev);

endmodule

// File: rtl/shim_cfg_sync_bank.sv
// Bank of config synchronisers into the SPI domain with atomic gated-group commit,
// independent ungated commits, a hold-immune disable path and change pulses.
module shim_cfg_sync_bank
    import shim_cfg_sync_bank_pkg::*;
#(
    parameter int unsigned NUM_FIELDS   = DFLT_NUM_FIELDS,
    parameter int unsigned FIELD_W      = DFLT_FIELD_W,
    parameter int unsigned DEPTH        = DFLT_DEPTH,
    parameter int unsigned STABLE_COUNT = DFLT_STABLE_COUNT,
    parameter int unsigned EN_IDX       = SPI_EN,
    parameter logic [NUM_FIELDS-1:0]         GATE_MASK = NUM_FIELDS'(DFLT_GATE_MASK),
    parameter logic [NUM_FIELDS*FIELD_W-1:0] RESET_VAL = (NUM_FIELDS*FIELD_W)'(DFLT_RESET_VAL)
) (
    input  logic                          spi_clk,
    input  logic                          sync_reset,
    input  logic [NUM_FIELDS*FIELD_W-1:0] cfg_in,
    input  logic                          hold,
    output logic [NUM_FIELDS*FIELD_W-1:0] cfg_out,
    output logic                          cfg_valid,
    output logic                          commit_pulse,
    output logic [NUM_FIELDS-1:0]         changed_mask
);

    localparam logic [NUM_FIELDS-1:0] GROUP = GATE_MASK | (NUM_FIELDS'(1) << EN_IDX);

    logic [NUM_FIELDS-1:0][FIELD_W-1:0] sync_val;
    logic [NUM_FIELDS-1:0][FIELD_W-1:0] out_q;
    logic [NUM_FIELDS-1:0][FIELD_W-1:0] out_d;
    logic [NUM_FIELDS-1:0]              stable;
    logic [NUM_FIELDS-1:0]              changed;
    logic                               group_go;
    logic                               disable_go;

    for (genvar i = 0; i < int'(NUM_FIELDS); i++) begin : g_field
        shim_cfg_field_sync #(
            .WIDTH        (FIELD_W),
            .DEPTH        (DEPTH),
            .STABLE_COUNT (STABLE_COUNT),
            .RESET_VAL    (RESET_VAL[i*FIELD_W +: FIELD_W])
        ) u_sync (
            .clk    (spi_clk),
            .rst    (sync_reset),
            .din    (cfg_in[i*FIELD_W +: FIELD_W]),
            .sync   (sync_val[i]),
            .stable (stable[i])
        );
    end

    // Commit decision: whole group or nothing; ungated fields on their own; disable overrides hold
    always_comb begin
        out_d      = out_q;
        changed    = '0;
        group_go   = !hold && stable[EN_IDX] && sync_val[EN_IDX][0] && ((stable & GROUP) == GROUP);
        disable_go = stable[EN_IDX] && !sync_val[EN_IDX][0];
        for (int i = 0; i < int'(NUM_FIELDS); i++) begin
            if (GROUP[i]) begin
                if (group_go) out_d[i] = sync_val[i];
            end else if (!hold && stable[i]) begin
                out_d[i] = sync_val[i];
            end
        end
        if (disable_go) out_d[EN_IDX] = '0;
        for (int i = 0; i < int'(NUM_FIELDS); i++) begin
            changed[i] = (out_d[i] != out_q[i]);
        end
    end

    always_ff @(posedge spi_clk or posedge sync_reset) begin
        if (sync_reset) begin
            out_q        <= RESET_VAL;
            cfg_valid    <= 1'b0;
            commit_pulse <= 1'b0;
            changed_mask <= '0;
        end else begin
            out_q        <= out_d;
            commit_pulse <= |changed;
            changed_mask <= changed;
            if (group_go) cfg_valid <= 1'b1;
        end
    end

    assign cfg_out = out_q;

endmodule

// File: tb/tb_shim_cfg_sync_bank.sv
// Self-checking bench for shim_cfg_sync_bank: history-window reference model plus directed scenarios.
module tb_shim_cfg_sync_bank;

    localparam int NF    = 5;
    localparam int FW    = 32;
    localparam int DEPTH = 3;
    localparam int SC    = 2;
    localparam int EN    = 3;
    localparam int HL    = DEPTH + SC + 1;
    localparam logic [NF-1:0] GM = 5'b00111;

    logic               spi_clk;
    logic               sync_reset;
    logic [NF*FW-1:0]   cfg_in;
    logic               hold;
    logic [NF*FW-1:0]   cfg_out;
    logic               cfg_valid;
    logic               commit_pulse;
    logic [NF-1:0]      changed_mask;

    int n_total = 0;
    int n_pass  = 0;

    shim_cfg_sync_bank dut (
        .spi_clk      (spi_clk),
        .sync_reset   (sync_reset),
        .cfg_in       (cfg_in),
        .hold         (hold),
        .cfg_out      (cfg_out),
        .cfg_valid    (cfg_valid),
        .commit_pulse (commit_pulse),
        .changed_mask (changed_mask)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    task automatic check(input string name, input logic [NF*FW-1:0] act, input logic [NF*FW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [NF*FW-1:0] pack5(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                               input logic [FW-1:0] c, input logic [FW-1:0] d,
                                               input logic [FW-1:0] e);
        return {e, d, c, b, a};
    endfunction

    // Reference model: hist[i][k] is the input sampled k+1 edges ago; a field is stable when the
    // synchronised view (k=DEPTH-1) has matched the SC+1 older samples and enough edges have passed
    logic [FW-1:0]              hist [NF][HL];
    logic [NF-1:0][FW-1:0]      m_out;
    logic [NF-1:0][FW-1:0]      m_nxt;
    logic [NF-1:0]              m_mask;
    logic [NF-1:0]              m_chg;
    logic [NF-1:0]              m_st;
    logic                       m_valid;
    logic                       m_pulse;
    logic                       m_grp;
    logic                       m_dis;
    int                         m_edges;

    always_comb begin
        m_nxt = m_out;
        m_chg = '0;
        m_st  = '0;
        for (int i = 0; i < NF; i++) begin
            m_st[i] = (m_edges >= SC);
            for (int k = DEPTH; k <= DEPTH + SC; k++) begin
                if (hist[i][k] != hist[i][DEPTH-1]) m_st[i] = 1'b0;
            end
        end
        m_grp = !hold && m_st[EN] && hist[EN][DEPTH-1][0];
        for (int i = 0; i < NF; i++) begin
            if (GM[i] || i == EN) m_grp = m_grp && m_st[i];
        end
        m_dis = m_st[EN] && !hist[EN][DEPTH-1][0];
        for (int i = 0; i < NF; i++) begin
            if (GM[i] || i == EN) begin
                if (m_grp) m_nxt[i] = hist[i][DEPTH-1];
            end else if (!hold && m_st[i]) begin
                m_nxt[i] = hist[i][DEPTH-1];
            end
        end
        if (m_dis) m_nxt[EN] = '0;
        for (int i = 0; i < NF; i++) m_chg[i] = (m_nxt[i] != m_out[i]);
    end

    always @(posedge spi_clk or posedge sync_reset) begin
        if (sync_reset) begin
            for (int i = 0; i < NF; i++)
                for (int k = 0; k < HL; k++) hist[i][k] <= '0;
            m_out   <= '0;
            m_valid <= 1'b0;
            m_pulse <= 1'b0;
            m_mask  <= '0;
            m_edges <= 0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                hist[i][0] <= cfg_in[i*FW +: FW];
                for (int k = 1; k < HL; k++) hist[i][k] <= hist[i][k-1];
            end
            m_out   <= m_nxt;
            m_pulse <= |m_chg;
            m_mask  <= m_chg;
            if (m_grp) m_valid <= 1'b1;
            if (m_edges < 1000) m_edges <= m_edges + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge spi_clk) begin
        check("cyc_out",   cfg_out, m_out);
        check("cyc_valid", (NF*FW)'(cfg_valid), (NF*FW)'(m_valid));
        check("cyc_pulse", (NF*FW)'(commit_pulse), (NF*FW)'(m_pulse));
        check("cyc_mask",  (NF*FW)'(changed_mask), (NF*FW)'(m_mask));
    end

    task automatic step(input int n);
        repeat (n) @(posedge spi_clk);
        #1;
    endtask

    task automatic set_field(input int idx, input logic [FW-1:0] val);
        cfg_in[idx*FW +: FW] = val;
    endtask

    initial begin
        cfg_in     = '0;
        hold       = 1'b0;
        sync_reset = 1'b1;
        step(3);
        check("rst_out",   cfg_out, '0);
        check("rst_valid", (NF*FW)'(cfg_valid), '0);
        check("rst_pulse", (NF*FW)'(commit_pulse), '0);
        check("rst_mask",  (NF*FW)'(changed_mask), '0);

        // Basic latency: step sampled at edge 1, commit visible after edge 7
        sync_reset = 1'b0;
        set_field(0, 32'h1234);
        set_field(EN, 32'h1);
        step(6);
        check("t1_e6_out",   cfg_out, '0);
        check("t1_e6_pulse", (NF*FW)'(commit_pulse), '0);
        step(1);
        check("t1_e7_out",   cfg_out, pack5(32'h1234, 0, 0, 1, 0));
        check("t1_model",    m_out,   pack5(32'h1234, 0, 0, 1, 0));
        check("t1_valid",    (NF*FW)'(cfg_valid), 1);
        check("t1_pulse",    (NF*FW)'(commit_pulse), 1);
        check("t1_mask",     (NF*FW)'(changed_mask), (NF*FW)'(5'b01001));
        step(1);
        check("t1_pulse_end", (NF*FW)'(commit_pulse), '0);
        check("t1_mask_end",  (NF*FW)'(changed_mask), '0);
        step(4);

        // Unstable gated field blocks the whole group until it settles
        set_field(0, 32'h11);
        set_field(2, 32'h22);
        for (int t = 0; t < 10; t++) begin
            set_field(1, (t % 2 == 1) ? 32'h5 : 32'h6);
            step(2);
        end
        check("t2_blocked", cfg_out, pack5(32'h1234, 0, 0, 1, 0));
        set_field(1, 32'hAA);
        step(6);
        check("t2_e6_out", cfg_out, pack5(32'h1234, 0, 0, 1, 0));
        step(1);
        check("t2_e7_out",  cfg_out, pack5(32'h11, 32'hAA, 32'h22, 1, 0));
        check("t2_mask",    (NF*FW)'(changed_mask), (NF*FW)'(5'b00111));
        check("t2_model",   m_out,   pack5(32'h11, 32'hAA, 32'h22, 1, 0));
        step(4);

        // Hold defers gated and ungated commits; release commits both on the next edge
        hold = 1'b1;
        set_field(2, 32'h7);
        set_field(4, 32'h1);
        step(10);
        check("t3_held_out",   cfg_out, pack5(32'h11, 32'hAA, 32'h22, 1, 0));
        check("t3_held_pulse", (NF*FW)'(commit_pulse), '0);
        hold = 1'b0;
        step(1);
        check("t3_rel_out",  cfg_out, pack5(32'h11, 32'hAA, 32'h7, 1, 1));
        check("t3_rel_mask", (NF*FW)'(changed_mask), (NF*FW)'(5'b10100));
        step(4);

        // Disable propagates through hold; gated slots and cfg_valid are retained
        hold = 1'b1;
        set_field(EN, 32'h0);
        step(6);
        check("t4_e6_out", cfg_out, pack5(32'h11, 32'hAA, 32'h7, 1, 1));
        step(1);
        check("t4_e7_out",   cfg_out, pack5(32'h11, 32'hAA, 32'h7, 0, 1));
        check("t4_valid",    (NF*FW)'(cfg_valid), 1);
        check("t4_mask",     (NF*FW)'(changed_mask), (NF*FW)'(5'b01000));
        step(2);
        hold = 1'b0;
        step(4);

        // Ungated field commits with the enable low
        set_field(4, 32'h0);
        step(10);
        check("t5_pre_out", cfg_out, pack5(32'h11, 32'hAA, 32'h7, 0, 0));
        set_field(4, 32'h1);
        step(6);
        check("t5_e6_out", cfg_out, pack5(32'h11, 32'hAA, 32'h7, 0, 0));
        step(1);
        check("t5_e7_out", cfg_out, pack5(32'h11, 32'hAA, 32'h7, 0, 1));
        check("t5_mask",   (NF*FW)'(changed_mask), (NF*FW)'(5'b10000));
        step(4);

        // Reset mid-qualification: immediate clear, no pulse afterwards
        cfg_in = pack5(32'h55, 0, 0, 0, 0);
        step(5);
        sync_reset = 1'b1;
        #1;
        check("t6_async_out",   cfg_out, '0);
        check("t6_async_valid", (NF*FW)'(cfg_valid), '0);
        step(2);
        sync_reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            check("t6_no_pulse", (NF*FW)'(commit_pulse), '0);
            check("t6_out_zero", cfg_out, '0);
        end

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 15) == 0)
                    set_field(i, (i == EN) ? FW'($urandom_range(0, 1)) : FW'($urandom_range(0, 3)));
            end
            hold       = ($urandom_range(0, 3) == 0);
            sync_reset = ($urandom_range(0, 399) == 0);
            step(1);
        end
        sync_reset = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
